freq_div_prog: RTL and testbench
================================

FREQ_DIV_PROG -- requirements
Module: freq_div_prog

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent tick channels, 1..16.
REQ-002 SHALL have parameter CNT_W, default 28: divisor and counter width per channel.
REQ-003 SHALL have parameter DIV_INIT, default 625000: divisor loaded into every channel at reset.
REQ-004 SHALL have port iCLK  input  1  single clock for all logic.
REQ-005 SHALL have port iRESETn  input  1  asynchronous reset, active low.
REQ-006 SHALL have port iCLR  input  1  synchronous clear of all channel counters.
REQ-007 SHALL have port iEN  input  N_CH  per-channel count enable.
REQ-008 SHALL have port iWR_EN  input  1  divisor write strobe.
REQ-009 SHALL have port iWR_CH  input  4  target channel index of the write.
REQ-010 SHALL have port iWR_DIV  input  CNT_W  new divisor value.
REQ-011 SHALL have port oTICK  output  N_CH  one-cycle tick pulse per channel.
REQ-012 SHALL have port oWAVE  output  N_CH  per-channel square wave.
REQ-013 SHALL have port oERR  output  1  one-cycle pulse flagging a rejected write.

Function
REQ-014 SHALL keep, per channel k, a divisor register div[k] and a counter cnt[k], both CNT_W bits.
REQ-015 SHALL count cnt[k] 0..div[k]-1 when iEN[k]=1; on the edge where cnt[k]==div[k]-1: cnt[k]<=0, oTICK[k]<=1; otherwise cnt[k]+1, oTICK[k]<=0.
REQ-016 SHALL make oTICK registered: tick period exactly div[k] cycles; first tick after reset high in the cycle following the div[k]-th enabled edge.
REQ-017 SHALL, for div[k]==1, hold oTICK[k] continuously high while iEN[k]=1.
REQ-018 SHALL, when iEN[k]=0, hold cnt[k] and drive oTICK[k]=0; counting resumes from the held value.
REQ-019 SHALL accept a write when iWR_EN=1, iWR_CH<N_CH and iWR_DIV!=0: div[iWR_CH]<=iWR_DIV, cnt<=0, oTICK<=0 for that channel on the same edge.
REQ-020 SHALL reject a write with iWR_CH>=N_CH or iWR_DIV==0: no state change, oERR=1 for exactly the next cycle.
REQ-021 SHALL give an accepted write priority over a coincident terminal count on the same channel: tick suppressed.
REQ-022 SHALL, on iCLR=1: all cnt<=0, oTICK<=0, oWAVE<=0; div unchanged; iCLR has priority over counting, and a coincident valid write still loads div.
REQ-023 SHALL leave channels not addressed by a write unaffected.

Reset
REQ-024 SHALL, while iRESETn=0, asynchronously force cnt=0, div=DIV_INIT, oTICK=0, oWAVE=0, oERR=0 for all channels.
REQ-025 SHALL release reset synchronously to iCLK; the first count edge is the first rising edge with iRESETn=1.
REQ-026 SHALL, on reset asserted mid-period, discard partial counts and any pending oERR.

Configuration
REQ-027 SHALL use macro FREQ_DIV_WAVE_EN to include the square-wave generator.
REQ-028 SHALL, with FREQ_DIV_WAVE_EN defined, toggle oWAVE[k] on every edge that sets oTICK[k]=1 (50% duty for divisor d: period 2d).
REQ-029 SHALL, with FREQ_DIV_WAVE_EN undefined, tie oWAVE to 0 and synthesise no toggle flops.

Verification (N_CH=2, CNT_W=8, DIV_INIT=5)
REQ-030 SHALL check reset release, iEN=2'b11 -> oTICK[0] and oTICK[1] high one cycle after edges 5, 10, 15; oWAVE toggles at each tick.
REQ-031 SHALL check a write of ch1 div=3 at cycle 7 -> ch1 cnt restarts, ticks after edges 10, 13, 16; ch0 unaffected.
REQ-032 SHALL check writes with ch=2 and with div=0 -> oERR pulses one cycle each, div values unchanged.
REQ-033 SHALL check iEN[0]=0 for 4 cycles at cnt=2 -> no tick; next tick 4 cycles late; div=1 write -> oTICK[0] continuously high.
REQ-034 SHALL check iCLR at cycle 3 together with a ch0 div=7 write -> counters 0, oWAVE=0, next ch0 tick after 7 edges; iRESETn pulse mid-period -> all outputs 0, div=5.

Source files
------------

// File: rtl/freq_div_prog.sv
// Programmable N-channel tick divider; FREQ_DIV_WAVE_EN adds a per-channel square-wave output.
// Latency: oTICK/oERR/oWAVE registered, valid the cycle after the deciding edge.
// Backpressure: none; iEN[k]=0 freezes channel k, writes are accepted or flagged on oERR at once.
module freq_div_prog #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 28,
  parameter int DIV_INIT = 625000
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  input  logic              iCLR,
  input  logic [N_CH-1:0]   iEN,
  input  logic              iWR_EN,
  input  logic [3:0]        iWR_CH,
  input  logic [CNT_W-1:0]  iWR_DIV,
  output logic [N_CH-1:0]   oTICK,
  output logic [N_CH-1:0]   oWAVE,
  output logic              oERR
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);

  logic [CNT_W-1:0] div_q [N_CH];
  logic [CNT_W-1:0] div_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  tick_q, tick_d;
  logic             err_q, err_d;
  logic             wr_ok;

  always_comb begin
    wr_ok = iWR_EN && ({1'b0, iWR_CH} < 5'(N_CH)) && (iWR_DIV != '0);
    err_d = iWR_EN && !wr_ok;
    for (int k = 0; k < N_CH; k++) begin
      div_d[k]  = div_q[k];
      cnt_d[k]  = cnt_q[k];
      tick_d[k] = 1'b0;
      // A write restarts its channel and swallows a coincident terminal count.
      if (wr_ok && (iWR_CH == 4'(k))) begin
        div_d[k] = iWR_DIV;
        cnt_d[k] = '0;
      end else if (!iCLR && iEN[k]) begin
        if (cnt_q[k] >= div_q[k] - ONE) begin
          cnt_d[k]  = '0;
          tick_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + ONE;
        end
      end
      if (iCLR) begin
        cnt_d[k] = '0;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      for (int k = 0; k < N_CH; k++) begin
        div_q[k] <= DIV_RST;
        cnt_q[k] <= '0;
      end
      tick_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        div_q[k] <= div_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign oTICK = tick_q;
  assign oERR  = err_q;

`ifdef FREQ_DIV_WAVE_EN
  logic [N_CH-1:0] wave_q, wave_d;

  always_comb begin
    wave_d = iCLR ? '0 : (wave_q ^ tick_d);
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      wave_q <= '0;
    end else begin
      wave_q <= wave_d;
    end
  end

  assign oWAVE = wave_q;
`else
  assign oWAVE = '0;
`endif

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed bench for freq_div_prog (N_CH=2, CNT_W=8, DIV_INIT=5); oWAVE expectation follows FREQ_DIV_WAVE_EN.
module tb_freq_div_prog;

  localparam int N_CH     = 2;
  localparam int CNT_W    = 8;
  localparam int DIV_INIT = 5;

  logic             iCLK = 1'b0;
  logic             iRESETn;
  logic             iCLR;
  logic [N_CH-1:0]  iEN;
  logic             iWR_EN;
  logic [3:0]       iWR_CH;
  logic [CNT_W-1:0] iWR_DIV;
  logic [N_CH-1:0]  oTICK;
  logic [N_CH-1:0]  oWAVE;
  logic             oERR;

  freq_div_prog #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
    .iCLK    (iCLK),
    .iRESETn (iRESETn),
    .iCLR    (iCLR),
    .iEN     (iEN),
    .iWR_EN  (iWR_EN),
    .iWR_CH  (iWR_CH),
    .iWR_DIV (iWR_DIV),
    .oTICK   (oTICK),
    .oWAVE   (oWAVE),
    .oERR    (oERR)
  );

  always #5 iCLK = ~iCLK;

  int         n_checks = 0;
  int         n_errors = 0;
  int         e = 0;
  logic [1:0] exp_wave = 2'b00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock edge, then compare the registered outputs against expectations.
  task automatic edge_chk(input string tag, input logic [1:0] xt, input logic xe);
    @(posedge iCLK);
    #1;
    e++;
`ifdef FREQ_DIV_WAVE_EN
    exp_wave = exp_wave ^ xt;
`endif
    check($sformatf("%s tick e%0d", tag, e), 32'(oTICK), 32'(xt));
    check($sformatf("%s wave e%0d", tag, e), 32'(oWAVE), 32'(exp_wave));
    check($sformatf("%s err e%0d", tag, e), 32'(oERR), 32'(xe));
  endtask

  task automatic do_reset();
    iRESETn = 1'b0;
    iCLR    = 1'b0;
    iEN     = '0;
    iWR_EN  = 1'b0;
    iWR_CH  = '0;
    iWR_DIV = '0;
    repeat (2) @(posedge iCLK);
    #1;
    check("rst tick", 32'(oTICK), 32'd0);
    check("rst wave", 32'(oWAVE), 32'd0);
    check("rst err", 32'(oERR), 32'd0);
    iRESETn  = 1'b1;
    e        = 0;
    exp_wave = 2'b00;
  endtask

  initial begin
    logic t0, t1;

    // Basic counting from reset release, then a clear mid-run.
    do_reset();
    iEN = 2'b11;
    for (int i = 1; i <= 15; i++) edge_chk("t1", (i % 5 == 0) ? 2'b11 : 2'b00, 1'b0);
    exp_wave = 2'b00;
    iCLR = 1'b1;
    edge_chk("t1 clr", 2'b00, 1'b0);
    iCLR = 1'b0;
    for (int i = 0; i < 5; i++) edge_chk("t1 after clr", (i == 4) ? 2'b11 : 2'b00, 1'b0);

    // ch1 divisor rewritten to 3 on edge 7; ch0 keeps its period.
    do_reset();
    iEN = 2'b11;
    for (int i = 1; i <= 20; i++) begin
      iWR_EN  = (i == 7);
      iWR_CH  = 4'd1;
      iWR_DIV = 8'd3;
      t0 = (i % 5 == 0);
      t1 = (i == 5) || (i >= 10 && ((i - 10) % 3 == 0));
      edge_chk("t2", {t1, t0}, 1'b0);
    end
    iWR_EN = 1'b0;

    // Rejected writes flag oERR for one cycle and leave divisors intact.
    do_reset();
    iWR_EN = 1'b1; iWR_CH = 4'd2;  iWR_DIV = 8'd4;
    edge_chk("t3 badch", 2'b00, 1'b1);
    iWR_EN = 1'b0;
    edge_chk("t3 idle", 2'b00, 1'b0);
    iWR_EN = 1'b1; iWR_CH = 4'd0;  iWR_DIV = 8'd0;
    edge_chk("t3 zero", 2'b00, 1'b1);
    iWR_CH = 4'd15; iWR_DIV = 8'd1;
    edge_chk("t3 ch15", 2'b00, 1'b1);
    iWR_CH = 4'd1;  iWR_DIV = 8'd5;
    edge_chk("t3 valid", 2'b00, 1'b0);
    iWR_EN = 1'b0;
    iEN = 2'b11;
    for (int i = 1; i <= 5; i++) edge_chk("t3 div kept", (i == 5) ? 2'b11 : 2'b00, 1'b0);

    // Enable gap on ch0, then div=1 written over a terminal count.
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      iEN[1]  = 1'b1;
      iEN[0]  = !((i >= 3 && i <= 6) || i >= 24);
      iWR_EN  = (i == 19);
      iWR_CH  = 4'd0;
      iWR_DIV = 8'd1;
      t0 = (i == 9) || (i == 14) || (i >= 20 && i <= 23);
      t1 = (i % 5 == 0);
      edge_chk("t4", {t1, t0}, 1'b0);
    end
    iWR_EN = 1'b0;

    // Clear with coincident ch0 div=7 write, then a rejected write and async reset.
    do_reset();
    iEN = 2'b11;
    for (int i = 1; i <= 13; i++) begin
      iCLR    = (i == 3);
      iWR_EN  = (i == 3) || (i == 13);
      iWR_CH  = (i == 13) ? 4'd2 : 4'd0;
      iWR_DIV = 8'd7;
      if (i == 3) exp_wave = 2'b00;
      t0 = (i == 10);
      t1 = (i == 8) || (i == 13);
      edge_chk("t5", {t1, t0}, (i == 13));
    end
    iCLR   = 1'b0;
    iWR_EN = 1'b0;
    #2;
    iRESETn = 1'b0;
    #1;
    check("t5 async tick", 32'(oTICK), 32'd0);
    check("t5 async wave", 32'(oWAVE), 32'd0);
    check("t5 async err", 32'(oERR), 32'd0);
    do_reset();
    iEN = 2'b11;
    for (int i = 1; i <= 5; i++) edge_chk("t5 div reset", (i == 5) ? 2'b11 : 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
